// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the ICache/LSB memory arbiter: FSM encodings, opcode IDs, access sizes.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_L = 2'd2,
    ARB_DRAIN  = 2'd3
  } arb_state_t;

  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_LHU = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;

  localparam logic [1:0] MC_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MC_SIZE_HALF = 2'd1;
  localparam logic [1:0] MC_SIZE_WORD = 2'd2;

  function automatic logic [1:0] mc_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: mc_size = MC_SIZE_BYTE;
      OP_LH, OP_LHU, OP_SH: mc_size = MC_SIZE_HALF;
      default:              mc_size = MC_SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_streak.sv
// Saturating count of LSB grants made while a fetch waits; at_max hands the next grant to ICache.
// Updates only when en is high; clr wins over inc.
module mem_arb_streak #(
  parameter int MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] count,
  output logic       at_max
);

  localparam logic [3:0] MAX_V = 4'(MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 4'd0;
    end else if (en) begin
      if (clr)
        count <= 4'd0;
      else if (inc && count != MAX_V)
        count <= count + 4'd1;
    end
  end

  assign at_max = (count == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// Shares the memory-controller port between ICache fetches and LSB loads/stores, one transaction
// at a time; done pulses arrive the cycle after mc_done, and rdy=0 freezes every register.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              jump_wrong,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_done,
  output logic [31:0]       ic_data,
  input  logic              lsb_req,
  input  logic              lsb_wr,
  input  logic [5:0]        lsb_opcode,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_wdata,
  output logic              lsb_done,
  output logic [31:0]       lsb_rdata,
  output logic              mc_req,
  output logic              mc_is_lsb,
  output logic              mc_wr,
  output logic [5:0]        mc_opcode,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [31:0]       mc_wdata,
  input  logic              mc_done,
  input  logic [31:0]       mc_rdata
);

  arb_state_t        state;
  logic              lat_is_lsb;
  logic              lat_wr;
  logic [5:0]        lat_opcode;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;

  logic       idle_gate, ic_ok, lsb_ok, grant_i, grant_l;
  logic       streak_inc, streak_clr, streak_at_max;
  logic [3:0] streak_count;

  // The IDLE cycle in which a done pulse is visible never grants, so the finishing
  // requester has time to drop its level request before it could be re-granted.
  always_comb begin
    idle_gate  = (state == ARB_IDLE) && !ic_done && !lsb_done;
    ic_ok      = idle_gate && ic_req && !jump_wrong;
    lsb_ok     = idle_gate && lsb_req && (lsb_wr || !jump_wrong);
    grant_i    = ic_ok && (streak_at_max || !lsb_ok);
    grant_l    = lsb_ok && !grant_i;
    streak_inc = grant_l && ic_req;
    streak_clr = grant_i || !ic_req;
  end

  mem_arb_streak #(.MAX(STREAK_MAX)) u_streak (
    .clk    (clk),
    .rst    (rst),
    .en     (rdy),
    .inc    (streak_inc),
    .clr    (streak_clr),
    .count  (streak_count),
    .at_max (streak_at_max)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      lat_is_lsb <= 1'b0;
      lat_wr     <= 1'b0;
      lat_opcode <= 6'd0;
      lat_addr   <= '0;
      lat_wdata  <= 32'd0;
      ic_done    <= 1'b0;
      ic_data    <= 32'd0;
      lsb_done   <= 1'b0;
      lsb_rdata  <= 32'd0;
    end else if (rdy) begin
      ic_done  <= 1'b0;
      lsb_done <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_l) begin
            state      <= ARB_BUSY_L;
            lat_is_lsb <= 1'b1;
            lat_wr     <= lsb_wr;
            lat_opcode <= lsb_opcode;
            lat_addr   <= lsb_addr;
            lat_wdata  <= lsb_wdata;
          end else if (grant_i) begin
            state      <= ARB_BUSY_I;
            lat_is_lsb <= 1'b0;
            lat_wr     <= 1'b0;
            lat_opcode <= OP_LW;
            lat_addr   <= ic_addr;
            lat_wdata  <= 32'd0;
          end
        end
        ARB_BUSY_I: begin
          if (mc_done) begin
            state <= ARB_IDLE;
            if (!jump_wrong) begin
              ic_done <= 1'b1;
              ic_data <= mc_rdata;
            end
          end else if (jump_wrong) begin
            state <= ARB_DRAIN;
          end
        end
        ARB_BUSY_L: begin
          // Stores are architecturally committed, so a flush never cancels them.
          if (mc_done) begin
            state <= ARB_IDLE;
            if (lat_wr || !jump_wrong) begin
              lsb_done  <= 1'b1;
              lsb_rdata <= mc_rdata;
            end
          end else if (jump_wrong && !lat_wr) begin
            state <= ARB_DRAIN;
          end
        end
        default: begin
          if (mc_done)
            state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign mc_req    = (state != ARB_IDLE);
  assign mc_is_lsb = lat_is_lsb;
  assign mc_wr     = lat_wr;
  assign mc_opcode = lat_opcode;
  assign mc_addr   = lat_addr;
  assign mc_wdata  = lat_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: plays both requesters and the memory controller by hand.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk, rst, rdy, jump_wrong;
  logic        ic_req, ic_done;
  logic [31:0] ic_addr, ic_data;
  logic        lsb_req, lsb_wr, lsb_done;
  logic [5:0]  lsb_opcode;
  logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
  logic        mc_req, mc_is_lsb, mc_wr, mc_done;
  logic [5:0]  mc_opcode;
  logic [31:0] mc_addr, mc_wdata, mc_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses;

  mem_arbiter #(.ADDR_W(32), .STREAK_MAX(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_opcode(lsb_opcode), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .mc_req(mc_req), .mc_is_lsb(mc_is_lsb), .mc_wr(mc_wr), .mc_opcode(mc_opcode),
    .mc_addr(mc_addr), .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic mc_complete(input logic [31:0] data);
    mc_done  = 1'b1;
    mc_rdata = data;
    tick();
    mc_done  = 1'b0;
    mc_rdata = 32'd0;
  endtask

  task automatic lsb_set(input logic wr, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] wd);
    lsb_req    = 1'b1;
    lsb_wr     = wr;
    lsb_opcode = op;
    lsb_addr   = a;
    lsb_wdata  = wd;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; jump_wrong = 1'b0;
    ic_req = 1'b0; ic_addr = 32'd0;
    lsb_req = 1'b0; lsb_wr = 1'b0; lsb_opcode = 6'd0; lsb_addr = 32'd0; lsb_wdata = 32'd0;
    mc_done = 1'b0; mc_rdata = 32'd0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_mc_req", {31'd0, mc_req}, 32'd0);
    check("rst_ic_done", {31'd0, ic_done}, 32'd0);
    check("rst_lsb_done", {31'd0, lsb_done}, 32'd0);
    check("rst_ic_data", ic_data, 32'd0);
    check("rst_lsb_rdata", lsb_rdata, 32'd0);
    check("rst_mc_addr", mc_addr, 32'd0);
    check("rst_streak", {28'd0, dut.u_streak.count}, 32'd0);

    // 1: lone fetch, completion after 4 busy cycles
    ic_req = 1'b1; ic_addr = 32'h100;
    tick();
    check("t1_mc_req", {31'd0, mc_req}, 32'd1);
    check("t1_is_lsb", {31'd0, mc_is_lsb}, 32'd0);
    check("t1_addr", mc_addr, 32'h100);
    check("t1_opcode", {26'd0, mc_opcode}, {26'd0, OP_LW});
    tick(); tick(); tick();
    check("t1_no_early_done", {31'd0, ic_done}, 32'd0);
    mc_complete(32'h00A00093);
    check("t1_ic_done", {31'd0, ic_done}, 32'd1);
    check("t1_ic_data", ic_data, 32'h00A00093);
    check("t1_mc_req_low", {31'd0, mc_req}, 32'd0);
    ic_req = 1'b0;
    tick();
    check("t1_done_pulse_end", {31'd0, ic_done}, 32'd0);

    // 2: simultaneous requests, LSB first
    ic_req = 1'b1; ic_addr = 32'h104;
    lsb_set(1'b0, OP_LW, 32'h2000, 32'd0);
    tick();
    check("t2_lsb_first", {31'd0, mc_is_lsb}, 32'd1);
    check("t2_lsb_addr", mc_addr, 32'h2000);
    tick();
    mc_complete(32'hDEADBEEF);
    check("t2_lsb_done", {31'd0, lsb_done}, 32'd1);
    check("t2_lsb_rdata", lsb_rdata, 32'hDEADBEEF);
    check("t2_no_ic_done", {31'd0, ic_done}, 32'd0);
    lsb_req = 1'b0;
    tick();
    check("t2_gap_idle", {31'd0, mc_req}, 32'd0);
    tick();
    check("t2_fetch_grant", {31'd0, mc_req & ~mc_is_lsb}, 32'd1);
    check("t2_fetch_addr", mc_addr, 32'h104);
    check("t2_streak_clr", {28'd0, dut.u_streak.count}, 32'd0);
    tick();
    mc_complete(32'h12345678);
    check("t2_ic_data", ic_data, 32'h12345678);
    ic_req = 1'b0;
    tick();

    // 3: four LSB grants with a waiting fetch, then the fetch wins
    ic_req = 1'b1; ic_addr = 32'h108;
    for (int k = 0; k < 4; k++) begin
      lsb_set(1'b0, OP_LW, 32'h2100 + 32'(4 * k), 32'd0);
      tick();
      check("t3_lsb_grant", {31'd0, mc_req & mc_is_lsb}, 32'd1);
      check("t3_streak", {28'd0, dut.u_streak.count}, 32'(k + 1));
      tick();
      mc_complete(32'(k));
      check("t3_lsb_done", {31'd0, lsb_done}, 32'd1);
      lsb_req = 1'b0;
      tick();
    end
    lsb_set(1'b0, OP_LW, 32'h2200, 32'd0);
    tick();
    check("t3_ic_wins", {31'd0, mc_req & ~mc_is_lsb}, 32'd1);
    check("t3_ic_addr", mc_addr, 32'h108);
    check("t3_streak_zero", {28'd0, dut.u_streak.count}, 32'd0);
    tick();
    mc_complete(32'hAAAA5555);
    check("t3_ic_done", {31'd0, ic_done}, 32'd1);
    ic_req = 1'b0;
    tick();
    tick();
    check("t3_lsb_after", {31'd0, mc_req & mc_is_lsb}, 32'd1);
    check("t3_lsb_after_addr", mc_addr, 32'h2200);
    tick();
    mc_complete(32'h0);
    lsb_req = 1'b0;
    tick();

    // 4: flush during a fetch drains without ic_done; flush in IDLE blocks fetch
    ic_req = 1'b1; ic_addr = 32'h200;
    tick();
    tick();
    jump_wrong = 1'b1;
    tick();
    jump_wrong = 1'b0; ic_req = 1'b0;
    check("t4_drain_req", {31'd0, mc_req}, 32'd1);
    tick(); tick();
    check("t4_drain_hold", {31'd0, mc_req}, 32'd1);
    check("t4_drain_addr", mc_addr, 32'h200);
    mc_complete(32'h00000BAD);
    check("t4_no_ic_done", {31'd0, ic_done}, 32'd0);
    check("t4_idle", {31'd0, mc_req}, 32'd0);
    ic_req = 1'b1; ic_addr = 32'h300; jump_wrong = 1'b1;
    tick();
    check("t4_flush_blocks_fetch", {31'd0, mc_req}, 32'd0);
    ic_req = 1'b0; jump_wrong = 1'b0;
    tick();

    // 5: store survives a coincident flush; a load under flush is not granted
    lsb_set(1'b1, OP_SW, 32'h3000, 32'hCAFEF00D);
    tick();
    check("t5_wr", {31'd0, mc_wr}, 32'd1);
    check("t5_opcode", {26'd0, mc_opcode}, {26'd0, OP_SW});
    check("t5_wdata", mc_wdata, 32'hCAFEF00D);
    tick();
    jump_wrong = 1'b1;
    mc_complete(32'h0);
    check("t5_store_done", {31'd0, lsb_done}, 32'd1);
    lsb_set(1'b0, OP_LB, 32'h3004, 32'd0);
    tick();
    check("t5_lb_gap", {31'd0, mc_req}, 32'd0);
    tick();
    check("t5_lb_blocked", {31'd0, mc_req}, 32'd0);
    lsb_set(1'b1, OP_SB, 32'h3008, 32'h000000EE);
    tick();
    check("t5_sb_under_flush", {31'd0, mc_req & mc_is_lsb}, 32'd1);
    check("t5_sb_opcode", {26'd0, mc_opcode}, {26'd0, OP_SB});
    jump_wrong = 1'b0;
    tick();
    mc_complete(32'h0);
    check("t5_sb_done", {31'd0, lsb_done}, 32'd1);
    lsb_req = 1'b0;
    tick();

    // 6: rdy=0 freezes a load in flight; exactly one done pulse
    lsb_set(1'b0, OP_LW, 32'h4000, 32'd0);
    tick();
    pulses = 0;
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (lsb_done) pulses++;
    end
    check("t6_hold_req", {31'd0, mc_req}, 32'd1);
    check("t6_hold_addr", mc_addr, 32'h4000);
    check("t6_hold_opcode", {26'd0, mc_opcode}, {26'd0, OP_LW});
    rdy = 1'b1;
    tick();
    mc_complete(32'h00000055);
    if (lsb_done) pulses++;
    check("t6_rdata", lsb_rdata, 32'h00000055);
    lsb_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (lsb_done) pulses++;
    end
    check("t6_one_pulse", 32'(pulses), 32'd1);

    // Reset mid-transaction returns to IDLE
    lsb_set(1'b0, OP_LW, 32'h5000, 32'd0);
    tick();
    check("rst_mid_busy", {31'd0, mc_req}, 32'd1);
    lsb_req = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_idle", {31'd0, mc_req}, 32'd0);
    check("rst_mid_addr", mc_addr, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
